aes128_iter_ctrl: RTL and testbench
===================================

# aes128_iter_ctrl

Iterative AES-128 encryption controller: accepts one plaintext/key pair over a valid/ready handshake and runs one shared round datapath for 10 clock cycles. Round keys are expanded on the fly, one per cycle, alongside the state. The result is presented on a valid/ready output port. It is the area-reduced, sequenced alternative to the fully unrolled combinational encryption path. It sits between the host-side message buffer and the ciphertext sink.

## Interface
- `NR`, 10: number of rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data`/`in_key` are valid.
- `in_ready`  out  1: controller can accept a block (IDLE only).
- `in_data`  in  128: plaintext. Bits [127:120] are FIPS-197 byte 0; column-major order.
- `in_key`  in  128: cipher key, same byte order as `in_data`.
- `out_valid`  out  1: `out_data` holds a finished ciphertext.
- `out_ready`  in  1: sink accepts `out_data`.
- `out_data`  out  128: ciphertext.
- `busy`  out  1: high in RUN or DONE.
- `round`  out  4: round currently being computed (1..10) in RUN; 0 otherwise.

## Operation
- Registers:
  - `st` (128): state.
  - `rk` (128): current round key.
  - `rnd` (4): round counter.
  - FSM: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: `st` <= `in_data ^ in_key`; `rk` <= `in_key`; `rnd` <= 1; go to RUN.
- **RUN**, every cycle:
  - `nk` = keystep(`rk`, rcon[`rnd`]).
  - `st` <= round(`st`, `nk`, mix = (`rnd` != 10)); `rk` <= `nk`; `rnd` <= `rnd`+1.
  - When `rnd`==10, go to DONE instead of incrementing.
- round = SubBytes, ShiftRows, then MixColumns if `mix`, then XOR `nk`.
- keystep (standard FIPS-197 word expansion):
  - `w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}`.
  - `w1' = w1 ^ w0'`, `w2' = w2 ^ w1'`, `w3' = w3 ^ w2'`.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. All GF(2^8) arithmetic uses polynomial 0x11b.
- **DONE**
  - `out_valid`=1; `out_data`=`st`.
  - On `out_valid & out_ready`: go to IDLE.
- `out_data` is driven from `st` in all states. It is only meaningful while `out_valid`=1.
- Inputs are ignored while `in_ready`=0. No new block is accepted in RUN or DONE.
- `in_data`/`in_key` are sampled only on the accept edge. They may change freely afterwards.

## Timing
- Reset values:
  - State = IDLE; `st`, `rk` = 0; `rnd` = 0.
  - `in_ready`=1, `out_valid`=0, `busy`=0, `round`=0, `out_data`=0.
- Asserting `rst_n` low mid-RUN or in DONE aborts the operation immediately. The block is discarded and no `out_valid` follows.
- Latency: accept on edge E; `out_valid` rises after edge E+10.
- Output hold: `out_valid` stays high and `out_data` stays stable until the handshake edge.
- Return to IDLE: the FSM is in IDLE after the handshake edge. `in_ready` is 1 in the following cycle.
- Throughput: with `in_valid` and `out_ready` held high, one block per 12 cycles.
- `out_ready` asserted before `out_valid` has no effect.
- `in_valid` high in DONE is held off (`in_ready`=0) until IDLE.
- `round` sequence in RUN is 1,2,…,10, one value per cycle.
- Timing paths:
  - The round step is one combinational stage from `st`/`rk` to the next-state registers.
  - No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Structure
- Package `aes_pkg` holds:
  - the S-box constant array;
  - the rcon table;
  - `xtime` and `sub_word`/`rot_word` functions;
  - the FSM state enum;
  - the AES block width localparam (128).
- Sub-module `aes_round_step` is combinational: inputs `st`, `rk`, `rcon`, `mix`; outputs next state and `nk`.
  - It contains SubBytes, ShiftRows, MixColumns, AddRoundKey and keystep.
  - The controller holds only the registers, the FSM and the counter.

## Test plan
- FIPS-197 App. B: `in_data`=3243f6a8885a308d313198a2e0370734, `in_key`=2b7e151628aed2a6abf7158809cf4f3c, `out_ready`=1.
  - `out_data`=3925841d02dc09fbdc118597196a0b32.
  - `out_valid` rises exactly 10 cycles after the accept edge.
- FIPS-197 App. C.1: 00112233445566778899aabbccddeeff with key 000102030405060708090a0b0c0d0e0f.
  - Result 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `round` steps 1..10 during RUN.
- Back-pressure: `out_ready`=0 for 20 cycles after `out_valid`.
  - `out_data` remains stable and `in_ready` stays 0.
  - Release: handshake; IDLE; next accept 2 cycles after release.
- Back-to-back: both vectors presented with `in_valid` held high and `out_ready`=1.
  - Both results are correct and in order.
  - Accept edges are 12 cycles apart.
  - `in_data` changed during RUN does not corrupt the result.
- Reset: `rst_n` pulsed low at round 5.
  - All outputs at reset values; no `out_valid`.
  - A subsequent App. B vector encrypts correctly.
- Handshake edge cases:
  - `in_valid` pulsed for exactly the accept cycle only → still encrypted.
  - `out_ready` held high from reset → `out_valid` is high for exactly 1 cycle per block.

Source files
------------

// File: rtl/aes128_iter_ctrl_pkg.sv
// Shared AES-128 constants, helpers and controller state type.
// The S-box, rcon table and byte helpers are used by the round step.
package aes_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the 4-bit round counter; unused slots read as zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // One MixColumns column; row 0 sits in the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes128_iter_ctrl_if.sv
// Block-in / ciphertext-out handshake bundle plus status of the AES controller.
interface aes128_iter_ctrl_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic [BLOCK_W-1:0] in_key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               busy;
    logic [3:0]         round;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy, round
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy, round
    );

endinterface

// File: rtl/aes128_iter_ctrl_round_step.sv
// Combinational AES-128 round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey with the next round key expanded in the same stage.
module aes_round_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] st,
    input  logic [BLOCK_W-1:0] rk,
    input  logic [7:0]         rcon,
    input  logic               mix,
    output logic [BLOCK_W-1:0] st_next,
    output logic [BLOCK_W-1:0] nk
);

    logic [31:0]        w0, w1, w2, w3;
    logic [BLOCK_W-1:0] sr;
    logic [BLOCK_W-1:0] mc;

    always_comb begin
        w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rcon, 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0]  ^ w2;
        nk = {w0, w1, w2, w3};
    end

    // Byte 4c+r lives at bits [127-8(4c+r) -: 8]; row r rotates left by r columns.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(4*c + r) -: 8] = SBOX[st[127 - 8*(4*((c + r) % 4) + r) -: 8]];
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
        end
    end

    assign st_next = (mix ? mc : sr) ^ nk;

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one shared round stage, ten passes
// per block, with the result held on a valid/ready output until taken.
module aes128_iter_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    aes128_iter_ctrl_if.slave bus
);

    if (NR != 10) begin : g_nr_check
        $error("aes128_iter_ctrl supports only NR = 10");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t             state;
    logic [BLOCK_W-1:0] st;
    logic [BLOCK_W-1:0] rk;
    logic [3:0]         rnd;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [3:0]         round_q;

    logic [BLOCK_W-1:0] st_next;
    logic [BLOCK_W-1:0] nk;

    aes_round_step u_round_step (
        .st      (st),
        .rk      (rk),
        .rcon    (RCON[rnd]),
        .mix     (rnd != LAST_RND),
        .st_next (st_next),
        .nk      (nk)
    );

    // Status outputs are registered alongside the state so that neither
    // in_ready nor out_valid has a combinational path from the handshake inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            st          <= '0;
            rk          <= '0;
            rnd         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            round_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        st         <= bus.in_data ^ bus.in_key;
                        rk         <= bus.in_key;
                        rnd        <= 4'd1;
                        round_q    <= 4'd1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    st <= st_next;
                    rk <= nk;
                    if (rnd == LAST_RND) begin
                        round_q     <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rnd     <= rnd + 4'd1;
                        round_q <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    round_q     <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = st;
    assign bus.busy      = busy_q;
    assign bus.round     = round_q;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Scenario bench for aes128_iter_ctrl using FIPS-197 vectors and a scoreboard
// queue of expected ciphertexts consumed at each output handshake.
module tb_aes128_iter_ctrl;

    localparam logic [127:0] VB_P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] VB_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] VB_C = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] VC_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VC_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VC_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes128_iter_ctrl_if bus ();

    aes128_iter_ctrl #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Output handshake happens at the next rising edge; score it mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected got %h required no output", bus.out_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data got %h required %h", bus.out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block; returns once the accept edge has passed (edge index in acc).
    task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c,
                        input bit drop_valid, output int acc);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = p;
        bus.in_key   = k;
        exp_q.push_back(c);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        tick();
        acc = cyc;
        if (drop_valid) begin
            bus.in_valid = 1'b0;
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_out(input string name, output int vcyc);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout out_valid=%b required 1", name, bus.out_valid);
        end
        vcyc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checks += 5;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", bus.busy); end
        if (bus.round !== 4'd0) begin errors++; $display("FAIL reset_round got %0d required 0", bus.round); end
        if (bus.out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h required 0", bus.out_data); end
        rst_n = 1'b1;
        tick();
    endtask

    // App. B with a single-cycle in_valid pulse and out_ready held high.
    task automatic test_vector_b();
        int acc, vcyc;
        bus.out_ready = 1'b1;
        send(VB_P, VB_K, VB_C, 1'b1, acc);
        checks += 2;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b_busy got %b required 1", bus.busy); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b_in_ready got %b required 0", bus.in_ready); end
        wait_out("b", vcyc);
        checks++;
        if (vcyc - acc != 10) begin errors++; $display("FAIL b_latency got %0d required 10", vcyc - acc); end
        tick();
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b_valid_one_cycle got %b required 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b_in_ready_after got %b required 1", bus.in_ready); end
    endtask

    task automatic test_vector_c1_rounds();
        int acc;
        bus.out_ready = 1'b1;
        send(VC_P, VC_K, VC_C, 1'b1, acc);
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (bus.round !== 4'(i)) begin errors++; $display("FAIL c1_round got %0d required %0d", bus.round, i); end
            tick();
        end
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL c1_out_valid got %b required 1", bus.out_valid); end
        if (bus.round !== 4'd0) begin errors++; $display("FAIL c1_round_done got %0d required 0", bus.round); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc, vcyc, rel;
        bus.out_ready = 1'b0;
        send(VB_P, VB_K, VB_C, 1'b1, acc);
        wait_out("bp", vcyc);
        bus.in_valid = 1'b1;
        bus.in_data  = VC_P;
        bus.in_key   = VC_K;
        exp_q.push_back(VC_C);
        for (int i = 0; i < 20; i++) begin
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b required 1", bus.out_valid); end
            if (bus.out_data !== VB_C) begin errors++; $display("FAIL bp_hold_data got %h required %h", bus.out_data, VB_C); end
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got %b required 0", bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        rel = cyc;
        tick();
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_in_ready got %b required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_out_valid got %b required 0", bus.out_valid); end
        tick();
        checks += 2;
        if (cyc - rel != 2) begin errors++; $display("FAIL bp_reaccept got %0d required 2", cyc - rel); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_reaccept_busy got %b required 1", bus.busy); end
        bus.in_valid = 1'b0;
        wait_out("bp2", vcyc);
        tick();
    endtask

    task automatic test_back_to_back();
        int a1, a2, n, vcyc;
        bus.out_ready = 1'b1;
        send(VB_P, VB_K, VB_C, 1'b0, a1);
        bus.in_data = VC_P;
        bus.in_key  = VC_K;
        exp_q.push_back(VC_C);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        tick();
        a2 = cyc;
        checks++;
        if (a2 - a1 != 12) begin errors++; $display("FAIL b2b_spacing got %0d required 12", a2 - a1); end
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
        wait_out("b2b", vcyc);
        tick();
    endtask

    task automatic test_reset_mid_run();
        int acc, n, vcnt, vcyc;
        bus.out_ready = 1'b1;
        send(VB_P, VB_K, VB_C, 1'b1, acc);
        n = 0;
        while (bus.round !== 4'd5 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.round !== 4'd5) begin errors++; $display("FAIL rst_reach_round5 got %0d required 5", bus.round); end
        rst_n = 1'b0;
        #2;
        checks += 5;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", bus.out_valid); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", bus.busy); end
        if (bus.round !== 4'd0) begin errors++; $display("FAIL rst_round got %0d required 0", bus.round); end
        if (bus.out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data got %h required 0", bus.out_data); end
        void'(exp_q.pop_back());
        repeat (2) tick();
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin errors++; $display("FAIL rst_no_out_valid got %0d cycles required 0", vcnt); end
        send(VB_P, VB_K, VB_C, 1'b1, acc);
        wait_out("rst_b", vcyc);
        checks++;
        if (vcyc - acc != 10) begin errors++; $display("FAIL rst_b_latency got %0d required 10", vcyc - acc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_vector_b();
        test_vector_c1_rounds();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
